// File: rtl/dft_bin_accumulator.sv
// rtl/dft_bin_accumulator.sv - DFT bin multiply-accumulate controller driving an external sequential multiplier
module dft_bin_accumulator #(
    parameter int width   = 32,
    parameter int points  = 8,
    parameter int gap     = 4,
    parameter int timeout = 4 * width,
    localparam int accWidth = 2 * width + $clog2(points)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  sign,
    input  logic [width-1:0]      sampleIn,
    input  logic [width-1:0]      coefIn,
    input  logic                  pairValid,
    output logic                  pairReady,
    output logic [width-1:0]      mulX,
    output logic [width-1:0]      mulY,
    output logic                  mulSign,
    output logic                  mulDataIn,
    input  logic                  mulDataOut,
    input  logic [2*width-1:0]    mulProd,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [accWidth-1:0]   sum
);

    localparam int CNT_W    = $clog2(points + 1);
    localparam int GAP_W    = (gap > 0) ? $clog2(gap + 1) : 1;
    localparam int GAP_LAST = (gap > 0) ? gap - 1 : 0;
    localparam int TMO_W    = (timeout > 1) ? $clog2(timeout + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PAIR,
        S_LOAD,
        S_MUL,
        S_ACC,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sign;
    logic [accWidth-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
    logic [width-1:0]      r_x;
    logic [width-1:0]      r_y;
    logic [2*width-1:0]    r_prod;
    logic [accWidth-1:0]   r_sum;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [TMO_W-1:0]      r_tmo_cnt;

    logic                  w_gap_last;
    logic                  w_tmo;
    logic                  w_last_pair;
    logic [accWidth-1:0]   w_ext;

    assign w_gap_last  = (r_gap_cnt == GAP_W'(GAP_LAST));
    assign w_tmo       = (r_tmo_cnt == TMO_W'(timeout - 1));
    assign w_last_pair = (r_cnt == CNT_W'(points - 1));

    // Fill the upper bits with the product's sign only for signed operands.
    always_comb begin
        w_ext              = {accWidth{r_sign & r_prod[2*width-1]}};
        w_ext[2*width-1:0] = r_prod;
    end

    always_comb begin
        w_next    = r_state;
        pairReady = 1'b0;
        mulDataIn = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_WAIT_PAIR;
            end
            S_WAIT_PAIR: begin
                pairReady = 1'b1;
                if (pairValid) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_gap_last) w_next = S_MUL;
            end
            S_MUL: begin
                mulDataIn = 1'b1;
                if (mulDataOut)  w_next = S_ACC;
                else if (w_tmo)  w_next = S_IDLE;
            end
            S_ACC: begin
                w_next = w_last_pair ? S_DONE : S_WAIT_PAIR;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_prod    <= '0;
            r_sum     <= '0;
            r_gap_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= sign;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_WAIT_PAIR: begin
                    if (pairValid) begin
                        r_x       <= sampleIn;
                        r_y       <= coefIn;
                        r_gap_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    r_tmo_cnt <= '0;
                end
                S_MUL: begin
                    if (mulDataOut)  r_prod    <= mulProd;
                    else if (w_tmo)  r_err     <= 1'b1;
                    else             r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
                S_ACC: begin
                    r_acc <= r_acc + w_ext;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_sum <= r_acc;
                end
                default: ;
            endcase
        end
    end

    assign mulX    = r_x;
    assign mulY    = r_y;
    assign mulSign = r_sign;
    assign error   = r_err;
    assign sum     = r_sum;

endmodule

// File: doc/dft_bin_accumulator.md
DFT_BIN_ACCUMULATOR -- requirements
Module: dft_bin_accumulator

Interface
REQ-001 SHALL have parameter width, default 32, meaning the operand width of sample and coefficient.
REQ-002 SHALL have parameter points, default 8, meaning the number of sample/coefficient pairs per accumulation (points >= 1).
REQ-003 SHALL have parameter gap, default 4, meaning the minimum number of cycles mulDataIn is held low between multiplier operations.
REQ-004 SHALL have parameter timeout, default 4*width, meaning the maximum cycles allowed from mulDataIn rising to mulDataOut high.
REQ-005 SHALL define accWidth = 2*width + clog2(points) as a derived local width.
REQ-006 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, sampled high in IDLE to begin an accumulation.
REQ-009 SHALL have port sign, input, 1, 0 = unsigned and 1 = signed operands, latched on an accepted start.
REQ-010 SHALL have ports sampleIn and coefIn, input, width each, the operand pair.
REQ-011 SHALL have port pairValid, input, 1, and port pairReady, output, 1; a pair transfers on a cycle where both are high.
REQ-012 SHALL have ports mulX and mulY, output, width each, mulSign, output, 1, and mulDataIn, output, 1, as the drive to the sequential multiplier.
REQ-013 SHALL have port mulDataOut, input, 1, and port mulProd, input, 2*width, as the multiplier result.
REQ-014 SHALL have ports busy, output, 1, done, output, 1, error, output, 1, and sum, output, accWidth.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_PAIR, LOAD, MUL, ACC, and DONE.
REQ-016 IDLE: start=1 SHALL latch sign, clear the accumulator, pair counter and error, and go to WAIT_PAIR; busy=1 in every state except IDLE.
REQ-017 WAIT_PAIR: pairReady=1; on transfer SHALL register the operands onto mulX/mulY and go to LOAD; pairReady=0 in all other states.
REQ-018 LOAD: mulDataIn=0 for exactly gap cycles with mulX, mulY and mulSign stable, then go to MUL.
REQ-019 MUL: mulDataIn=1 and SHALL hold mulX/mulY stable; on the first cycle mulDataOut=1, capture mulProd and go to ACC.
REQ-020 ACC (1 cycle): SHALL drive mulDataIn=0, add mulProd to the accumulator sign-extended when the latched sign=1 and zero-extended otherwise, with the result wrapping modulo 2^accWidth.
REQ-021 ACC: SHALL increment the pair counter; if it reaches points, go to DONE, otherwise go to WAIT_PAIR.
REQ-022 DONE (1 cycle): done=1, sum <= accumulator, then go to IDLE; sum SHALL hold its value until the next DONE.
REQ-023 SHALL keep mulDataIn low for at least gap consecutive cycles between any two high periods, including across accumulations.
REQ-024 MUL timeout: if mulDataOut stays low for timeout cycles, SHALL set error=1 (sticky until the next accepted start), drop mulDataIn, and go to IDLE without asserting done.
REQ-025 start outside IDLE SHALL be ignored; pairValid outside WAIT_PAIR SHALL not transfer.
REQ-026 mulDataOut high outside MUL SHALL be ignored.
REQ-027 Latency per pair from transfer to ACC SHALL be gap + (multiplier latency) + 1 cycles.

Reset
REQ-028 rstn=0 SHALL force IDLE asynchronously, including mid-operation, with partial results discarded.
REQ-029 rstn=0 SHALL clear the accumulator and pair counter.
REQ-030 rstn=0 SHALL set pairReady, mulDataIn, mulSign, busy, done and error to 0, and mulX, mulY and sum to 0.

Verification
REQ-031 width=8, points=4, sign=1, pairs (3,5),(-2,7),(10,10),(-1,-1) -> one done pulse, sum=102, error=0.
REQ-032 width=8, points=2, sign=0, pairs (255,255),(255,255) -> sum=130050, no wrap.
REQ-033 width=8, points=1, sign=1, pair (-128,-128) -> sum=16384.
REQ-034 mulDataIn monitor over back-to-back accumulations -> every low interval >= gap cycles; mulX/mulY never change while mulDataIn=1.
REQ-035 Stalled multiplier (mulDataOut tied 0) -> error=1 after timeout cycles in MUL, done never asserted, IDLE reached.
REQ-036 rstn pulsed low during the second MUL of 4 -> all outputs 0 immediately; a new start with pairs (1,1)x4 gives sum=4.
